// File: rtl/rs_channel_pkg.sv
// Shared definitions for the channel-impairment blocks (injector, comparator, bit generator).
package rs_channel_pkg;

  localparam int          WINDOW_LEN = 100;
  localparam int          RATE_W     = 7;
  localparam logic [15:0] LFSR_POLY  = 16'hB400;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] rate);
    return (rate > RATE_W'(WINDOW_LEN)) ? RATE_W'(WINDOW_LEN) : rate;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), steps once per cycle with advance high.
// Zero seed is replaced by 1 so the register never locks up.
module lfsr16
  import rs_channel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d, seed_eff;

  always_comb begin
    seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
    state_d  = state_q;
    if (advance) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= seed_eff;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/bit_error_injector.sv
// Flips exactly min(error_rate,100) bits per 100-bit window at LFSR-chosen positions.
// Latency: clk_in rise before edge k -> bit_out/clk_out valid after edge k+1; no backpressure.
module bit_error_injector
  import rs_channel_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          STROBE_HIGH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              clk_in,
  input  logic [RATE_W-1:0] error_rate,
  output logic              bit_out,
  output logic              clk_out,
  output logic              inject_flag,
  output logic [RATE_W-1:0] window_errors,
  output logic              window_done
);

  localparam int CNT_W = $clog2(STROBE_HIGH + 1);

  logic              clk_in_d1_q, clk_in_d2_q, bit_d1_q;
  state_e            state_q, state_d;
  logic [RATE_W-1:0] bit_idx_q, bit_idx_d;
  logic [RATE_W-1:0] err_cnt_q, err_cnt_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0]  strb_cnt_q, strb_cnt_d;
  logic              bit_out_q, bit_out_d;
  logic              inject_q, inject_d;
  logic [RATE_W-1:0] win_err_q, win_err_d;
  logic              win_done_q, win_done_d;

  logic              ev, inject, hit, lfsr_adv;
  logic [RATE_W-1:0] rate_eff, remain, budget;
  logic [13:0]       prod_lfsr, prod_budget;
  logic [6:0]        lfsr_rand;
  logic [8:0]        lfsr_unused;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (lfsr_adv),
    .seed    (LFSR_SEED),
    .state   ({lfsr_unused, lfsr_rand})
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    err_cnt_d  = err_cnt_q;
    rate_d     = rate_q;
    strb_cnt_d = strb_cnt_q;
    bit_out_d  = bit_out_q;
    inject_d   = inject_q;
    win_err_d  = win_err_q;
    win_done_d = 1'b0;
    lfsr_adv   = 1'b0;
    inject     = 1'b0;

    ev = clk_in_d1_q & ~clk_in_d2_q;

    // Remaining flip budget vs. remaining slots: once they meet every slot must flip,
    // which is what makes the per-window count exact.
    rate_eff    = (bit_idx_q == '0) ? clamp_rate(error_rate) : rate_q;
    remain      = RATE_W'(WINDOW_LEN) - bit_idx_q;
    budget      = rate_eff - err_cnt_q;
    prod_lfsr   = {7'b0, lfsr_rand} * {7'b0, remain};
    prod_budget = {budget, 7'b0};
    hit         = (budget >= remain) || ((budget != '0) && (prod_lfsr < prod_budget));

    case (state_q)
      IDLE: begin
        bit_idx_d = '0;
        err_cnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (ev) begin
          inject   = hit;
          lfsr_adv = 1'b1;
          if (bit_idx_q == '0) rate_d = rate_eff;
          if (bit_idx_q == RATE_W'(WINDOW_LEN - 1)) begin
            win_err_d  = err_cnt_q + RATE_W'(inject);
            win_done_d = 1'b1;
            bit_idx_d  = '0;
            err_cnt_d  = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            err_cnt_d = err_cnt_q + RATE_W'(inject);
          end
        end
        if (!enable) begin
          state_d   = IDLE;
          bit_idx_d = '0;
          err_cnt_d = '0;
        end
      end
    endcase

    // A new event reloads the strobe counter, so back-to-back bits merge into one pulse.
    if (ev) begin
      bit_out_d  = bit_d1_q ^ inject;
      inject_d   = inject;
      strb_cnt_d = CNT_W'(STROBE_HIGH);
    end else if (strb_cnt_q != '0) begin
      strb_cnt_d = strb_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_in_d1_q <= 1'b0;
      clk_in_d2_q <= 1'b0;
      bit_d1_q    <= 1'b0;
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      err_cnt_q   <= '0;
      rate_q      <= '0;
      strb_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      inject_q    <= 1'b0;
      win_err_q   <= '0;
      win_done_q  <= 1'b0;
    end else begin
      clk_in_d1_q <= clk_in;
      clk_in_d2_q <= clk_in_d1_q;
      bit_d1_q    <= bit_in;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      err_cnt_q   <= err_cnt_d;
      rate_q      <= rate_d;
      strb_cnt_q  <= strb_cnt_d;
      bit_out_q   <= bit_out_d;
      inject_q    <= inject_d;
      win_err_q   <= win_err_d;
      win_done_q  <= win_done_d;
    end
  end

  assign bit_out       = bit_out_q;
  assign clk_out       = (strb_cnt_q != '0);
  assign inject_flag   = inject_q;
  assign window_errors = win_err_q;
  assign window_done   = win_done_q;

endmodule

// File: tb/tb_bit_error_injector.sv
// Randomized bench for bit_error_injector against a window-budget reference model.
module tb_bit_error_injector;

  logic       clk = 1'b0;
  logic       rst, enable, bit_in, clk_in;
  logic [6:0] error_rate;
  logic       bit_out, clk_out, inject_flag, window_done;
  logic [6:0] window_errors;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int flips    = 0;

  int m_lfsr, m_idx, m_errs, m_rate, m_win;
  bit m_run;

  bit_error_injector #(.LFSR_SEED(16'hACE1), .STROBE_HIGH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .bit_in        (bit_in),
    .clk_in        (clk_in),
    .error_rate    (error_rate),
    .bit_out       (bit_out),
    .clk_out       (clk_out),
    .inject_flag   (inject_flag),
    .window_errors (window_errors),
    .window_done   (window_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (window_done) done_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int lfsr_step(input int s);
    return (s >> 1) ^ (((s & 1) != 0) ? 'hB400 : 0);
  endfunction

  task automatic model_reset();
    m_lfsr = 'hACE1;
    m_idx  = 0;
    m_errs = 0;
    m_rate = 0;
    m_win  = 0;
    m_run  = 0;
  endtask

  // One strobed bit: rise before edge k, sample outputs after edge k+1.
  task automatic send_event(input bit b);
    int r, e;
    bit inj  = 0;
    bit done = 0;
    if (m_run) begin
      if (m_idx == 0) m_rate = (int'(error_rate) > 100) ? 100 : int'(error_rate);
      r   = 100 - m_idx;
      e   = m_rate - m_errs;
      inj = (e >= r) || (e > 0 && (m_lfsr % 128) * r < e * 128);
      m_lfsr = lfsr_step(m_lfsr);
      m_errs += int'(inj);
      m_idx++;
      if (m_idx == 100) begin
        m_win  = m_errs;
        done   = 1;
        m_idx  = 0;
        m_errs = 0;
      end
    end
    @(negedge clk); clk_in = 1'b1; bit_in = b;
    @(negedge clk); clk_in = 1'b0;
    @(negedge clk);
    check("bit_out", int'(bit_out), int'(b ^ inj));
    check("inject_flag", int'(inject_flag), int'(inj));
    check("clk_out_hi", int'(clk_out), 1);
    check("window_done", int'(window_done), int'(done));
    check("window_errors", int'(window_errors), m_win);
    flips += int'(bit_out != b);
    @(negedge clk);
  endtask

  task automatic set_enable(input bit v);
    @(negedge clk); enable = v;
    @(negedge clk);
    @(negedge clk);
    m_run = v;
  endtask

  task automatic run_window(input int rate_a, input int change_at, input int rate_b, input int exp);
    int d0 = done_cnt;
    error_rate = 7'(rate_a);
    flips = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == change_at) error_rate = 7'(rate_b);
      send_event(1'($urandom_range(1, 0)));
    end
    check("win_pulses", done_cnt - d0, 1);
    check("win_errors", int'(window_errors), exp);
    check("win_flips", flips, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bit_out"}, int'(bit_out), 0);
    check({tag, "_clk_out"}, int'(clk_out), 0);
    check({tag, "_inject"}, int'(inject_flag), 0);
    check({tag, "_win_err"}, int'(window_errors), 0);
    check({tag, "_win_done"}, int'(window_done), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; bit_in = 1'b0; clk_in = 1'b0; error_rate = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe shape: rises before edges 0 and 3 -> clk_out high after edges 1,2 and 4,5.
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      check("strobe_shape", int'(clk_out), (n == 2 || n == 3 || n == 5 || n == 6) ? 1 : 0);
      clk_in = (n == 0 || n == 3) ? 1'b1 : 1'b0;
      bit_in = 1'b1;
    end

    // Transparent pass-through.
    for (int i = 0; i < 200; i++) send_event(1'(i % 2));
    check("idle_no_done", done_cnt, 0);

    set_enable(1'b1);
    for (int w = 0; w < 3; w++) run_window(10, -1, 10, 10);

    run_window(0, -1, 0, 0);
    run_window(100, -1, 100, 100);
    run_window(127, -1, 127, 100);

    // Mid-window rate change only takes effect on the next window.
    run_window(20, 40, 50, 20);
    run_window(50, -1, 50, 50);

    // Reset mid-window: partial window discarded, LFSR restarts from seed.
    error_rate = 7'd30;
    for (int i = 0; i < 57; i++) send_event(1'($urandom_range(1, 0)));
    @(negedge clk); rst = 1'b1; clk_in = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    m_run = 1;
    run_window(30, -1, 30, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_error_injector.md
Name: bit_error_injector

Overview:
- Channel-impairment block between the encoder output and decoder input; the counterpart of the bit comparator.
- Takes the generator-side bit stream (bit + strobe clock), flips exactly N bits per 100-bit window, and re-emits bit + strobe.
- N is the requested error percentage. Error positions are chosen pseudo-randomly by a 16-bit LFSR.
- Window count is exact, so a downstream comparator must read back precisely N.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- STROBE_HIGH, 2, number of clk cycles clk_out is held high per emitted bit (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = inject errors, 0 = transparent pass-through
- bit_in  in  1  data bit from the generator/encoder
- clk_in  in  1  data strobe; each rising edge presents one bit_in
- error_rate  in  7  requested errors per 100 bits; values above 100 clamp to 100
- bit_out  out  1  bit_in XOR inject, held until the next emitted bit
- clk_out  out  1  output strobe, high for STROBE_HIGH cycles per bit
- inject_flag  out  1  1 when the current bit_out was flipped; held with bit_out
- window_errors  out  7  number of flips in the last completed window
- window_done  out  1  one-cycle pulse when a 100-bit window completes

Behaviour:
- Reset (rst high at posedge clk): all outputs 0; LFSR = seed; bit_idx = 0; err_cnt = 0; rate_q = 0; state IDLE; strobe counter 0. Reset wins over every other event, including mid-window and mid-strobe; a partial window is discarded.
- Input sampling: clk_in and bit_in are registered into d1 then d2 every cycle. An event exists when clk_in_d1 & ~clk_in_d2. bit_d1 is used as the data bit.
- Latency: clk_in rises before edge k → event evaluated at edge k+1 → bit_out/clk_out/inject_flag valid after edge k+1.
- One event emits one bit. A new event while clk_out is still high restarts the strobe count, so clk_out stays high. bit_out updates regardless.
- State IDLE (enable = 0):
  - Events pass through with inject = 0.
  - bit_idx and err_cnt held at 0.
  - LFSR does not advance.
  - enable = 1 moves to RUN.
- State RUN:
  - On the first event of each window (bit_idx = 0), rate_q = min(error_rate, 100). error_rate changes mid-window are ignored.
  - Per event: R = 100 − bit_idx (range 1..100); E = rate_q − err_cnt.
  - Decision: inject = (E ≥ R) OR (E > 0 AND lfsr[6:0]·R < E·128). Use 7×7 unsigned multiplies into 14-bit products.
  - The LFSR advances exactly once per event in RUN. It is Galois, polynomial x^16+x^14+x^13+x^11+1.
  - err_cnt += inject; bit_idx += 1.
  - At bit_idx = 99: window_errors = err_cnt + inject; window_done pulses; bit_idx and err_cnt return to 0.
- Guarantee: each complete window contains exactly rate_q flips. rate_q = 0 flips nothing; rate_q = 100 flips every bit.
- Dropping enable mid-window: move to IDLE on the next edge, discard the partial window, leave window_errors unchanged.

Decomposition:
- Shared package rs_channel_pkg:
  - WINDOW_LEN = 100
  - RATE_W = 7
  - LFSR_POLY = 16'hB400
  - state enum {IDLE, RUN}
  - The bit comparator uses the same WINDOW_LEN.
- Sub-module lfsr16 (inputs clk, rst, advance, seed; output state[15:0]). It is reusable by the random bit generator.
- Edge detect, window control, and strobe generator stay inline.

Test Plan:
- enable = 0, feed 200 events with alternating bits → bit_out equals bit_in for every event, inject_flag always 0, window_done never pulses.
- enable = 1, error_rate = 10, 300 events → three window_done pulses, each with window_errors = 10. Bench XOR count over each 100-bit window = 10.
- error_rate = 0, then 100, then 127 (clamped) across three windows → window_errors = 0, 100, 100; every bit inverted in the last two windows.
- Change error_rate from 20 to 50 at event 40 of a window → that window reports 20, the next reports 50.
- Latency/strobe: single clk_in rise, STROBE_HIGH = 2 → clk_out high on cycles k+1..k+2 after the 2-cycle pipeline. Two clk_in rises 3 cycles apart → two distinct clk_out pulses.
- Reset at event 57 of a window with error_rate = 30 → outputs 0 on the next cycle. The next 100 events report window_errors = 30. The LFSR sequence after reset matches the reset-state golden model.
